rf_writeback_ctrl: RTL
======================

Name: rf_writeback_ctrl

Overview:
Write-side initiator for the 32-entry RV32 integer register file. It accepts results from two producers, the ALU and the LSU, over valid/ready handshakes and arbitrates between them round-robin. Accepted results are buffered in a small in-order FIFO and drained onto the register file's single write port (rf_we/rf_waddr/rf_wdata). It also publishes a pending-write mask that decode uses for RAW hazard detection.

Parameters:
DATA_W, 32, width of result data and rf_wdata
ADDR_W, 5, register index width; register count = 2**ADDR_W
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle (when alu_valid=1)
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
lsu_valid  in  1  LSU result present
lsu_ready  out  1  LSU result accepted this cycle (when lsu_valid=1)
lsu_rd  in  ADDR_W  LSU destination register
lsu_data  in  DATA_W  LSU load data
rf_hold  in  1  register file write port unavailable; blocks FIFO pop
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)
pending_mask  out  2**ADDR_W  bit i=1 while a write to register xi is queued or on the rf port
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-drain):
  - FIFO emptied; pointers = 0; fifo_count = 0.
  - rf_we = 0; rf_waddr = 0; rf_wdata = 0; pending_mask = 0.
  - Round-robin pointer set to ALU-first.
  - In-flight entries are lost; no rf_we pulse follows reset.
- Arbitration:
  - At most one producer is accepted per cycle.
  - If only one producer is valid, it is granted.
  - If both are valid, the producer not granted at the last accepted transfer wins.
  - The round-robin pointer updates only on an accepted transfer.
- Ready:
  - Combinational: xxx_ready = grant_xxx AND (fifo_count < DEPTH).
  - No push into a full FIFO, even when a pop occurs in the same cycle.
  - Ready never depends on the same producer's data.
  - Producers hold valid, rd and data stable until ready.
- x0 suppression: a transfer with rd=0 completes the handshake (ready=1 under the normal rules) but is not enqueued. It does not change fifo_count and does not move the round-robin pointer.
- Pop:
  - Occurs when FIFO non-empty AND rf_hold=0.
  - The head is loaded into the output register, giving rf_we=1 for exactly one cycle with its rd/data.
  - When no pop occurs, rf_we=0 next cycle; rf_waddr/rf_wdata hold their last value.
- Latency: accepted at edge N (FIFO empty, rf_hold=0) -> rf_we=1 after edge N+1. Minimum 2 edges from handshake to write.
- Throughput: with rf_hold=0, one push and one pop per cycle is sustainable; fifo_count is unchanged on simultaneous push and pop.
- Ordering:
  - Strict FIFO order.
  - Two queued writes to the same rd reach the register file in acceptance order, so the last one wins.
- pending_mask:
  - Combinational OR over the rd of all valid FIFO entries, plus rf_waddr when rf_we=1.
  - Bit 0 is always 0.
  - A bit clears the cycle after its last outstanding write leaves the rf port.
- Pointer wrap: read and write pointers wrap modulo DEPTH. fifo_count distinguishes full from empty.
- rf_hold asserted while rf_we=1: the current write still completes; only subsequent pops are blocked.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF, FIFO empty -> alu_ready=1 that cycle; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF two edges later; pending_mask[5] set then cleared.
- Contention: both valid every cycle, ALU rd=1..4, LSU rd=11..14 -> accept order ALU1, LSU11, ALU2, LSU12, ... rf writes appear in that order.
- Full/backpressure: rf_hold=1, push 5 results with rd=1..5 -> first 4 accepted, fifo_count=4, 5th sees ready=0. Release rf_hold -> 4 writes on consecutive cycles, then the 5th is accepted and written.
- x0 discard: alu rd=0, data=0x1234 -> alu_ready=1, fifo_count stays 0, no rf_we, pending_mask=0.
- Same-rd ordering: ALU rd=7 data=0x11, then LSU rd=7 data=0x22 -> two rf writes to 7 in that order; pending_mask[7] stays high until the second write leaves the rf port.
- Reset mid-drain: 3 entries queued, assert reset for 1 cycle -> rf_we=0, fifo_count=0, pending_mask=0 immediately; no writes after release until a new handshake.

Source files
------------

// File: rtl/rf_writeback_ctrl.sv
// Write-back initiator for the integer register file: round-robin accept from ALU/LSU,
// in-order FIFO buffering, registered drain onto the single rf write port, RAW pending mask.
module rf_writeback_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_alu_valid,
    output logic                      o_alu_ready,
    input  logic [ADDR_W-1:0]         i_alu_rd,
    input  logic [DATA_W-1:0]         i_alu_data,
    input  logic                      i_lsu_valid,
    output logic                      o_lsu_ready,
    input  logic [ADDR_W-1:0]         i_lsu_rd,
    input  logic [DATA_W-1:0]         i_lsu_data,
    input  logic                      i_rf_hold,
    output logic                      o_rf_we,
    output logic [ADDR_W-1:0]         o_rf_waddr,
    output logic [DATA_W-1:0]         o_rf_wdata,
    output logic [2**ADDR_W-1:0]      o_pending_mask,
    output logic [$clog2(DEPTH):0]    o_fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_memRd   [DEPTH];
    logic [DATA_W-1:0] r_memData [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_lsuFirst;
    logic              r_rfWe;
    logic [ADDR_W-1:0] r_rfWaddr;
    logic [DATA_W-1:0] r_rfWdata;

    logic              w_notFull;
    logic              w_grantAlu;
    logic              w_grantLsu;
    logic              w_aluPush;
    logic              w_lsuPush;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pushRd;
    logic [DATA_W-1:0] w_pushData;
    logic [PW-1:0]     w_slotOffset;
    logic [2**ADDR_W-1:0] w_pendingMask;

    // r_lsuFirst remembers who should win the next tie: the producer that lost last time
    assign w_notFull  = (r_count < CW'(DEPTH));
    assign w_grantAlu = i_alu_valid & (~i_lsu_valid | ~r_lsuFirst);
    assign w_grantLsu = i_lsu_valid & (~i_alu_valid |  r_lsuFirst);
    assign o_alu_ready = w_grantAlu & w_notFull;
    assign o_lsu_ready = w_grantLsu & w_notFull;

    assign w_aluPush  = i_alu_valid & o_alu_ready & (i_alu_rd != '0);
    assign w_lsuPush  = i_lsu_valid & o_lsu_ready & (i_lsu_rd != '0);
    assign w_push     = w_aluPush | w_lsuPush;
    assign w_pushRd   = w_aluPush ? i_alu_rd   : i_lsu_rd;
    assign w_pushData = w_aluPush ? i_alu_data : i_lsu_data;
    assign w_pop      = (r_count != '0) & ~i_rf_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_lsuFirst <= 1'b0;
            r_rfWe     <= 1'b0;
            r_rfWaddr  <= '0;
            r_rfWdata  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr   <= r_rdPtr + PW'(1);
                r_rfWaddr <= r_memRd[r_rdPtr];
                r_rfWdata <= r_memData[r_rdPtr];
            end
            r_rfWe  <= w_pop;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_aluPush) begin
                r_lsuFirst <= 1'b1;
            end else if (w_lsuPush) begin
                r_lsuFirst <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are meaningful
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memRd[r_wrPtr]   <= w_pushRd;
            r_memData[r_wrPtr] <= w_pushData;
        end
    end

    always_comb begin
        w_pendingMask = '0;
        w_slotOffset  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slotOffset = PW'(i) - r_rdPtr;
            if (CW'(w_slotOffset) < r_count) begin
                w_pendingMask[r_memRd[i]] = 1'b1;
            end
        end
        if (r_rfWe) begin
            w_pendingMask[r_rfWaddr] = 1'b1;
        end
        w_pendingMask[0] = 1'b0;
    end

    assign o_pending_mask = w_pendingMask;
    assign o_fifo_count   = r_count;
    assign o_rf_we        = r_rfWe;
    assign o_rf_waddr     = r_rfWaddr;
    assign o_rf_wdata     = r_rfWdata;

endmodule
